// File: rtl/hilo_mult_pkg.sv
// Shared encodings for the HI/LO multiply controller: funct codes, MF read select
// codes and the controller state type.
package hilo_mult_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  localparam logic [1:0] LOHI_HI = 2'b01;
  localparam logic [1:0] LOHI_LO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } mult_state_t;

  function automatic logic is_mult_funct(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  endfunction

  function automatic logic is_mf_read(input logic [1:0] sel);
    return (sel == LOHI_HI) || (sel == LOHI_LO);
  endfunction

endpackage

// File: rtl/hilo_mult_ctrl_core.sv
// Iterative shift-add multiplier datapath: one partial product per step, unsigned
// operands, full 2*WIDTH result with no truncation.
module mult_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;

  // Sum after the current step; the controller commits this on the final step so
  // the result lands on the same edge the FSM leaves RUN.
  assign prod_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the shift and the add see each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
      acc_q    <= '0;
    end else if (step) begin
      acc_q    <= prod_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// HI/LO multiply controller: accepts MULT/MULTU from EX, sequences the iterative
// core, owns HI/LO and stalls the pipeline on structural/data hazards.
module hilo_mult_ctrl
  import hilo_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  input  logic [1:0]       mf_sel_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_data_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_t        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               mult_req;
  logic               accept;
  logic               last_step;
  logic               core_step;
  logic               op_signed;
  logic               op_sign;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] prod_fix;

  assign mult_req  = start_i && is_mult_funct(funct_i);
  // A new multiply may enter in DONE as well as IDLE; flush always drops it.
  assign accept    = mult_req && (state_q != S_RUN) && !flush_i;
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign core_step = (state_q == S_RUN) && !flush_i;

  // NOTE: every always_comb output gets a default before any conditional logic so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    op_signed = (funct_i == FUNCT_MULT);
    a_mag     = op_a_i;
    b_mag     = op_b_i;
    op_sign   = 1'b0;
    if (op_signed) begin
      a_mag   = op_a_i[WIDTH-1] ? -op_a_i : op_a_i;
      b_mag   = op_b_i[WIDTH-1] ? -op_b_i : op_b_i;
      op_sign = op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
    end
  end

  // Magnitude of the most negative operand is still exact as an unsigned WIDTH value.
  assign prod_fix = sign_q ? -prod_next : prod_next;

  mult_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (core_step),
    .mcand     (a_mag),
    .mplier    (b_mag),
    .prod_next (prod_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (accept) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
              sign_q  <= op_sign;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_RUN: begin
            if (last_step) begin
              state_q      <= S_DONE;
              {hi_q, lo_q} <= prod_fix;
              done_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o  = (state_q == S_RUN);
  assign stall_o = busy_o && (is_mf_read(mf_sel_i) || mult_req);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  // Reads come straight from the architectural registers; an in-flight product
  // is never forwarded, which is why a read during RUN must stall.
  always_comb begin
    mf_data_o = '0;
    unique case (mf_sel_i)
      LOHI_HI: mf_data_o = hi_q;
      LOHI_LO: mf_data_o = lo_q;
      default: mf_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl: a transaction-level model (countdown + 64-bit
// arithmetic) checked every cycle, plus hand-computed literal expectations.
module tb_hilo_mult_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [5:0]    funct_i;
  logic [W-1:0]  op_a_i;
  logic [W-1:0]  op_b_i;
  logic          flush_i;
  logic [1:0]    mf_sel_i;
  logic          busy_o;
  logic          stall_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;
  logic [W-1:0]  mf_data_o;

  int checks = 0;
  int errors = 0;

  hilo_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .funct_i   (funct_i),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .flush_i   (flush_i),
    .mf_sel_i  (mf_sel_i),
    .busy_o    (busy_o),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .mf_data_o (mf_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    if (f == 6'h18) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Model: a multiply occupies W cycles after acceptance, then HI/LO take the product.
  int           m_remain;
  logic [63:0]  m_pend;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic         m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remain <= 0;
      m_pend   <= '0;
      m_hi     <= '0;
      m_lo     <= '0;
      m_done   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (flush_i) begin
        m_remain <= 0;
      end else if (m_remain > 0) begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_done       <= 1'b1;
        end
      end else if (start_i && (funct_i == 6'h18 || funct_i == 6'h19)) begin
        m_remain <= W;
        m_pend   <= model_prod(funct_i, op_a_i, op_b_i);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 64'(busy_o), 64'(m_remain > 0));
      check("done", 64'(done_o), 64'(m_done));
      check("hi", 64'(hi_o), 64'(m_hi));
      check("lo", 64'(lo_o), 64'(m_lo));
      check("stall", 64'(stall_o),
            64'((m_remain > 0) && ((mf_sel_i == 2'b01) || (mf_sel_i == 2'b10) ||
                (start_i && (funct_i == 6'h18 || funct_i == 6'h19)))));
      check("mf_data", 64'(mf_data_o),
            64'((mf_sel_i == 2'b01) ? m_hi : (mf_sel_i == 2'b10) ? m_lo : '0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1;
    funct_i = f;
    op_a_i  = a;
    op_b_i  = b;
    cyc(1);
    start_i = 1'b0;
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic wait_done(output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (busy_o) busy_cycles++;
      if (done_o) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int bc;
    issue(f, a, b);
    wait_done(bc);
    check({name, "_busy_cycles"}, 64'(bc), 64'd32);
    check({name, "_hi"}, 64'(hi_o), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo_o), 64'(exp_lo));
    cyc(1);
  endtask

  initial begin
    int bc;
    int done_seen;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    funct_i  = 6'h00;
    op_a_i   = '0;
    op_b_i   = '0;
    flush_i  = 1'b0;
    mf_sel_i = 2'b00;

    check("model_min_sq", model_prod(6'h18, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
    check("model_neg1_sq", model_prod(6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'h0000_0000_0000_0001);
    check("model_umax_sq", model_prod(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("model_m2x3", model_prod(6'h18, 32'hFFFF_FFFE, 32'h0000_0003), 64'hFFFF_FFFF_FFFF_FFFA);

    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Basic results and edge values.
    run_op("multu_3x5", 6'h19, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F);
    run_op("mult_m2x3", 6'h18, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_umax", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_min", 6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mult_neg1", 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op("multu_zero", 6'h19, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000);

    // Non-multiply funct with start must be ignored.
    issue(6'h1A, 32'h0000_0007, 32'h0000_0009);
    cyc(2);
    @(negedge clk);
    check("ignore_funct_busy", 64'(busy_o), 64'd0);
    cyc(1);

    // MFHI five cycles into a multiply stalls until DONE, then reads the new HI.
    issue(6'h18, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    cyc(5);
    mf_sel_i = 2'b01;
    @(negedge clk);
    check("mfhi_stall", 64'(stall_o), 64'd1);
    check("mfhi_old", 64'(mf_data_o), 64'd0);
    wait_done(bc);
    check("mfhi_done_stall", 64'(stall_o), 64'd0);
    check("mfhi_new", 64'(mf_data_o), 64'h3FFF_FFFF);
    cyc(1);
    mf_sel_i = 2'b10;
    @(negedge clk);
    check("mflo_new", 64'(mf_data_o), 64'h0000_0001);
    cyc(1);
    mf_sel_i = 2'b00;

    // Back-to-back MULT: the second stays on start_i, stalls, and enters in DONE.
    start_i = 1'b1;
    funct_i = 6'h18;
    op_a_i  = 32'hFFFF_FFFE;
    op_b_i  = 32'h0000_0003;
    cyc(1);
    op_a_i  = 32'h0000_0005;
    op_b_i  = 32'hFFFF_FFF9;
    @(negedge clk);
    check("b2b_stall", 64'(stall_o), 64'd1);
    wait_done(bc);
    check("b2b_first", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("b2b_done_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(bc);
    check("b2b_second_cycles", 64'(bc), 64'd32);
    check("b2b_second", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFDD);
    cyc(1);

    // Flush mid-RUN leaves the prior HI/LO untouched and never pulses done.
    run_op("multu_prior", 6'h19, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h1234_5678);
    issue(6'h18, 32'h0000_0003, 32'h0000_0007);
    cyc(9);
    flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy_o), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hilo", {hi_o, lo_o}, 64'h0000_0000_1234_5678);
    cyc(1);

    // Flush and start in the same cycle: start is dropped.
    start_i = 1'b1;
    funct_i = 6'h19;
    op_a_i  = 32'h0000_0002;
    op_b_i  = 32'h0000_0002;
    flush_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 64'(busy_o), 64'd0);
    cyc(1);

    // Async reset between edges mid-RUN clears everything immediately.
    issue(6'h19, 32'hFFFF_FFFF, 32'h0000_0002);
    mf_sel_i = 2'b10;
    cyc(5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_stall", 64'(stall_o), 64'd0);
    check("arst_done", 64'(done_o), 64'd0);
    check("arst_hilo", {hi_o, lo_o}, 64'd0);
    check("arst_mf", 64'(mf_data_o), 64'd0);
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    check("arst_idle_busy", 64'(busy_o), 64'd0);
    check("arst_idle_hilo", {hi_o, lo_o}, 64'd0);
    mf_sel_i = 2'b00;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
